// File: rtl/br_predict_unit.sv
// Branch resolution unit with a direct-mapped BTB and per-entry
// saturating direction counters; predicts in IF, resolves and trains in EX.
package br_pkg;
  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_JAL  = 3'd2;
  localparam logic [2:0] BR_JALR = 3'd3;
  localparam logic [2:0] BR_BLT  = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BLTU = 3'd6;
  localparam logic [2:0] BR_BGEU = 3'd7;
endpackage

module br_predict_unit
  import br_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_branch_sig,
  input  logic [2:0]      ex_br_op,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic            ex_alu_lt,
  input  logic            ex_alu_ltu,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] new_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [CTR_BITS-1:0] CTR_WT =
    CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT =
    CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic              valid_q [ENTRIES];
  logic              valid_d [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [TAG_W-1:0]  tag_d   [ENTRIES];
  logic [XLEN-1:0]   tgt_q   [ENTRIES];
  logic [XLEN-1:0]   tgt_d   [ENTRIES];
  logic              jmp_q   [ENTRIES];
  logic              jmp_d   [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d [ENTRIES];

  logic              redirect_q;
  logic              redirect_d;
  logic [XLEN-1:0]   redirect_pc_q;
  logic [XLEN-1:0]   redirect_pc_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic              r_hit;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;

  logic              taken;
  logic              eff_taken;
  logic              is_cond;
  logic              is_jmp;
  logic [XLEN-1:0]   br_target;
  logic              train;
  logic              mispredict;

  // Fetch-side lookup: hit on valid entry with matching tag
  always_comb begin
    r_idx = if_pc[IDX_W+1:2];
    r_tag = if_pc[XLEN-1:IDX_W+2];
    r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    pred_taken = r_hit &&
      (jmp_q[r_idx] || ctr_q[r_idx][CTR_BITS-1]);
    pred_target = pred_taken ? tgt_q[r_idx]
                             : if_pc + XLEN'(4);
  end

  // Resolve branch direction and target for the EX instruction
  always_comb begin
    taken     = 1'b0;
    is_cond   = 1'b0;
    is_jmp    = 1'b0;
    br_target = ex_pc + ex_imm;
    case (ex_br_op)
      BR_BEQ: begin
        is_cond = 1'b1;
        taken   = (ex_alu_out == '0);
      end
      BR_BNE: begin
        is_cond = 1'b1;
        taken   = (ex_alu_out != '0);
      end
      BR_BLT: begin
        is_cond = 1'b1;
        taken   = ex_alu_lt;
      end
      BR_BGE: begin
        is_cond = 1'b1;
        taken   = !ex_alu_lt;
      end
      BR_BLTU: begin
        is_cond = 1'b1;
        taken   = ex_alu_ltu;
      end
      BR_BGEU: begin
        is_cond = 1'b1;
        taken   = !ex_alu_ltu;
      end
      BR_JAL: begin
        is_jmp    = 1'b1;
        taken     = 1'b1;
        br_target = ex_alu_out;
      end
      BR_JALR: begin
        is_jmp    = 1'b1;
        taken     = 1'b1;
        br_target = {ex_alu_out[XLEN-1:1], 1'b0};
      end
      default: begin
        taken = 1'b0;
      end
    endcase
    pc_plus4  = ex_pc + XLEN'(4);
    eff_taken = ex_branch_sig && taken;
    new_pc    = eff_taken ? br_target : pc_plus4;
  end

  // Next-state of the prediction tables on a trained branch
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    jmp_d   = jmp_q;
    ctr_d   = ctr_q;
    w_idx   = ex_pc[IDX_W+1:2];
    w_tag   = ex_pc[XLEN-1:IDX_W+2];
    w_hit   = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    train   = ex_valid && !ex_stall && ex_branch_sig;
    if (train && is_cond) begin
      jmp_d[w_idx] = 1'b0;
      if (!w_hit) begin
        valid_d[w_idx] = 1'b1;
        tag_d[w_idx]   = w_tag;
        ctr_d[w_idx]   = taken ? CTR_WT : CTR_WNT;
      end else if (taken) begin
        if (ctr_q[w_idx] != CTR_MAX)
          ctr_d[w_idx] = ctr_q[w_idx] + CTR_BITS'(1);
      end else begin
        if (ctr_q[w_idx] != '0)
          ctr_d[w_idx] = ctr_q[w_idx] - CTR_BITS'(1);
      end
    end else if (train && is_jmp) begin
      valid_d[w_idx] = 1'b1;
      tag_d[w_idx]   = w_tag;
      jmp_d[w_idx]   = 1'b1;
    end
    if (train && taken)
      tgt_d[w_idx] = br_target;
  end

  // Mispredict detection and statistics next-state
  always_comb begin
    mispredict = ex_valid && !ex_stall &&
      ((ex_pred_taken != eff_taken) ||
       (ex_pred_taken && (ex_pred_target != new_pc)));
    redirect_d    = mispredict;
    redirect_pc_d = new_pc;
    cnt_d         = cnt_q;
    if (mispredict && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Resettable state: entry valid bits, counters, redirect, stats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      cnt_q         <= '0;
    end else begin
      valid_q       <= valid_d;
      ctr_q         <= ctr_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      cnt_q         <= cnt_d;
    end
  end

  // Entry payload needs no reset; it is qualified by valid
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
    jmp_q <= jmp_d;
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign mispred_cnt = cnt_q;

endmodule

// File: tb/tb_br_predict_unit.sv
// Scoreboard bench for br_predict_unit: expected redirect/count
// pushed on drive, popped after the training edge.
module tb_br_predict_unit;
  import br_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic        ex_branch_sig;
  logic [2:0]  ex_br_op;
  logic [31:0] ex_alu_out;
  logic        ex_alu_lt;
  logic        ex_alu_ltu;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] new_pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] mispred_cnt;

  typedef struct packed {
    logic        mis;
    logic [31:0] pc;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  br_predict_unit dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_branch_sig  (ex_branch_sig),
    .ex_br_op       (ex_br_op),
    .ex_alu_out     (ex_alu_out),
    .ex_alu_lt      (ex_alu_lt),
    .ex_alu_ltu     (ex_alu_ltu),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .new_pc         (new_pc),
    .pc_plus4       (pc_plus4),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .mispred_cnt    (mispred_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic look(input logic [31:0] pc,
                      input logic tk,
                      input logic [31:0] tgt);
    if_pc = pc;
    #1;
    chk("pred_taken", 32'(pred_taken), 32'(tk));
    chk("pred_target", pred_target, tgt);
  endtask

  task automatic ex_op(input logic [2:0] op,
                       input logic bsig,
                       input logic [31:0] pc,
                       input logic [31:0] imm,
                       input logic [31:0] alu,
                       input logic lt,
                       input logic ltu,
                       input logic ptk,
                       input logic [31:0] ptgt,
                       input logic stall,
                       input logic [31:0] enpc,
                       input logic emis);
    exp_t e;
    @(negedge clk);
    ex_valid       = 1'b1;
    ex_stall       = stall;
    ex_br_op       = op;
    ex_branch_sig  = bsig;
    ex_pc          = pc;
    ex_imm         = imm;
    ex_alu_out     = alu;
    ex_alu_lt      = lt;
    ex_alu_ltu     = ltu;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
    #1;
    chk("new_pc", new_pc, enpc);
    chk("pc_plus4", pc_plus4, pc + 32'd4);
    if (emis) exp_cnt++;
    e.mis = emis;
    e.pc  = enpc;
    e.cnt = 16'(exp_cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("redirect", 32'(redirect), 32'(e.mis));
      if (e.mis)
        chk("redirect_pc", redirect_pc, e.pc);
      chk("mispred_cnt", 32'(mispred_cnt), 32'(e.cnt));
    end
  endtask

  initial begin
    rst = 1'b1;
    if_pc = 32'h100;
    ex_valid = 1'b0;
    ex_stall = 1'b0;
    ex_pc = '0;
    ex_imm = '0;
    ex_branch_sig = 1'b0;
    ex_br_op = BR_BEQ;
    ex_alu_out = '0;
    ex_alu_lt = 1'b0;
    ex_alu_ltu = 1'b0;
    ex_pred_taken = 1'b0;
    ex_pred_target = '0;
    #2;
    look(32'h100, 1'b0, 32'h104);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_cnt", 32'(mispred_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // taken BEQ on an empty table
    ex_op(BR_BEQ, 1, 32'h100, 32'h20, 0, 0, 0,
          0, 0, 0, 32'h120, 1);
    look(32'h100, 1'b1, 32'h120);
    look(32'h140, 1'b0, 32'h144);

    // not-taken streak saturates the counter at zero
    ex_op(BR_BEQ, 1, 32'h100, 32'h20, 1, 0, 0,
          1, 32'h120, 0, 32'h104, 1);
    look(32'h100, 1'b0, 32'h104);
    for (int i = 0; i < 4; i++)
      ex_op(BR_BEQ, 1, 32'h100, 32'h20, 1, 0, 0,
            0, 0, 0, 32'h104, 0);
    look(32'h100, 1'b0, 32'h104);
    ex_op(BR_BEQ, 1, 32'h100, 32'h20, 0, 0, 0,
          0, 0, 0, 32'h120, 1);
    look(32'h100, 1'b0, 32'h104);

    // JALR clears bit 0 and predicts as a jump
    ex_op(BR_JALR, 1, 32'h200, 0, 32'h305, 0, 0,
          0, 0, 0, 32'h304, 1);
    look(32'h200, 1'b1, 32'h304);
    ex_op(BR_JALR, 1, 32'h200, 0, 32'h305, 0, 0,
          1, 32'h304, 0, 32'h304, 0);
    look(32'h100, 1'b0, 32'h104);

    // unsigned and signed compares
    ex_op(BR_BLTU, 1, 32'h300, 32'h40, 2, 0, 1,
          0, 0, 0, 32'h340, 1);
    ex_op(BR_BGEU, 1, 32'h380, 32'h40, 2, 0, 1,
          0, 0, 0, 32'h384, 0);
    ex_op(BR_BGE, 1, 32'h384, 32'h10, 2, 1, 0,
          0, 0, 0, 32'h388, 0);
    ex_op(BR_BLT, 1, 32'h388, 32'h10, 2, 1, 0,
          0, 0, 0, 32'h398, 1);

    // non-branch predicted taken
    ex_op(BR_BEQ, 0, 32'h500, 0, 0, 0, 0,
          1, 32'h1000, 0, 32'h504, 1);
    // wrap of pc+4
    ex_op(BR_BEQ, 1, 32'hFFFF_FFFC, 8, 1, 0, 0,
          0, 0, 0, 32'h0, 0);

    // stalled mispredict: no redirect, no training
    ex_op(BR_BEQ, 1, 32'h608, 32'h10, 0, 0, 0,
          0, 0, 1, 32'h618, 0);
    look(32'h608, 1'b0, 32'h60C);

    // negative offset, then reset while redirect is high
    ex_op(BR_BNE, 1, 32'h404, 32'hFFFF_FFF8, 5, 0, 0,
          0, 0, 0, 32'h3FC, 1);
    look(32'h404, 1'b1, 32'h3FC);
    rst = 1'b1;
    exp_cnt = 0;
    #1;
    chk("arst_redirect", 32'(redirect), 32'd0);
    chk("arst_cnt", 32'(mispred_cnt), 32'(exp_cnt));
    look(32'h404, 1'b0, 32'h408);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_redirect", 32'(redirect), 32'd0);
    look(32'h200, 1'b0, 32'h204);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
